// File: rtl/float_to_fix.sv
// Reads a float16 from byte memory, converts it to a 16-bit two's-complement
// integer (truncating toward zero, saturating on overflow) and writes it back.
module float_to_fix #(
    parameter logic [7:0] IN_ADDR  = 8'd0,
    parameter logic [7:0] OUT_ADDR = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);

    typedef enum logic [3:0] {
        IDLE, RD_LO, RD_HI, CALC, SHIFT, NEG, WR_LO, WR_HI, DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_float;
    logic [15:0] r_mag;
    logic [15:0] r_result;
    logic [3:0]  r_cnt;
    logic        r_left;
    logic        r_trap;
    logic        r_sat;

    logic [4:0]  w_exp;
    logic        w_low_trap;
    logic        w_high_trap;
    logic        w_left;
    logic [3:0]  w_cnt;

    // Biased exponent 25 is the unshifted point (e = 10).
    assign w_exp       = r_float[14:10];
    assign w_low_trap  = (w_exp < 5'd15);
    assign w_high_trap = (w_exp >= 5'd30);
    assign w_left      = (w_exp > 5'd25);

    always_comb begin
        w_cnt = 4'd0;
        if (!(w_low_trap || w_high_trap)) begin
            if (w_left) w_cnt = 4'(w_exp - 5'd25);
            else        w_cnt = 4'(5'd25 - w_exp);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_next = RD_LO;
            RD_LO:      w_state_next = RD_HI;
            RD_HI:      w_state_next = CALC;
            CALC:       w_state_next = (w_cnt != 4'd0) ? SHIFT : NEG;
            SHIFT:      if (r_cnt == 4'd1) w_state_next = NEG;
            NEG:        w_state_next = WR_LO;
            WR_LO:      w_state_next = WR_HI;
            WR_HI:      w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_float  <= 16'd0;
            r_mag    <= 16'd0;
            r_result <= 16'd0;
            r_cnt    <= 4'd0;
            r_left   <= 1'b0;
            r_trap   <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            case (r_state)
                RD_LO: r_float[7:0]  <= mem_rd_data;
                RD_HI: r_float[15:8] <= mem_rd_data;
                CALC: begin
                    r_mag  <= {5'd0, 1'b1, r_float[9:0]};
                    r_cnt  <= w_cnt;
                    r_left <= w_left;
                    r_trap <= w_low_trap || w_high_trap;
                    r_sat  <= w_high_trap;
                end
                SHIFT: begin
                    r_mag <= r_left ? (r_mag << 1) : (r_mag >> 1);
                    r_cnt <= r_cnt - 4'd1;
                end
                NEG: begin
                    if (r_trap)
                        r_result <= r_sat ? (r_float[15] ? 16'h8000 : 16'h7FFF) : 16'h0000;
                    else
                        r_result <= r_float[15] ? (16'd0 - r_mag) : r_mag;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done        = (r_state == DONE);
        mem_wr_en   = 1'b0;
        mem_addr    = 8'd0;
        mem_wr_data = 8'd0;
        case (r_state)
            RD_LO: mem_addr = IN_ADDR;
            RD_HI: mem_addr = IN_ADDR + 8'd1;
            WR_LO: begin
                mem_wr_en   = 1'b1;
                mem_addr    = OUT_ADDR;
                mem_wr_data = r_result[7:0];
            end
            WR_HI: begin
                mem_wr_en   = 1'b1;
                mem_addr    = OUT_ADDR + 8'd1;
                mem_wr_data = r_result[15:8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_float_to_fix.sv
// Random and directed float16 conversions checked against a real-arithmetic
// reference model, plus reset-abort and held-start scenarios.
module tb_float_to_fix;

    localparam logic [7:0] IN_ADDR  = 8'd0;
    localparam logic [7:0] OUT_ADDR = 8'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] in_lo, in_hi;
    logic [7:0] out_lo, out_hi;
    int wr_lo_cnt, wr_hi_cnt, bad_wr_cnt;
    int n_checks, n_fail;

    always #5 clk = ~clk;

    float_to_fix #(.IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    // Memory model: input bytes at IN_ADDR, anything else reads a fixed pattern.
    always_comb begin
        if (mem_addr == IN_ADDR)             mem_rd_data = in_lo;
        else if (mem_addr == IN_ADDR + 8'd1) mem_rd_data = in_hi;
        else                                 mem_rd_data = mem_addr ^ 8'h5A;
    end

    initial begin
        out_lo = 8'h00; out_hi = 8'h00;
        wr_lo_cnt = 0; wr_hi_cnt = 0; bad_wr_cnt = 0;
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            if (mem_addr == OUT_ADDR) begin
                out_lo    <= mem_wr_data;
                wr_lo_cnt <= wr_lo_cnt + 1;
            end else if (mem_addr == OUT_ADDR + 8'd1) begin
                out_hi    <= mem_wr_data;
                wr_hi_cnt <= wr_hi_cnt + 1;
            end else begin
                bad_wr_cnt <= bad_wr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Value = (1 + m/1024) * 2^e, truncated toward zero; saturate when e >= 15.
    task automatic ref_model(input logic [15:0] f, output logic [15:0] res, output int lat);
        int  x, e, mag;
        real v;
        x = int'(f[14:10]);
        e = x - 15;
        if (x == 0 || e < 0) begin
            res = 16'h0000; lat = 6;
        end else if (e >= 15) begin
            res = f[15] ? 16'h8000 : 16'h7FFF; lat = 6;
        end else begin
            v   = (1.0 + real'(f[9:0]) / 1024.0) * (2.0 ** e);
            mag = $rtoi(v);
            res = f[15] ? 16'(-mag) : 16'(mag);
            lat = 6 + ((e > 10) ? (e - 10) : (10 - e));
        end
    endtask

    task automatic convert(input logic [15:0] f, input bit hold_start);
        logic [15:0] exp_res;
        int exp_lat, edges, lo0, hi0, bad0;
        ref_model(f, exp_res, exp_lat);
        @(negedge clk);
        in_lo = f[7:0];
        in_hi = f[15:8];
        lo0 = wr_lo_cnt; hi0 = wr_hi_cnt; bad0 = bad_wr_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        check("done_fall", {31'd0, done}, 32'd0);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        $display("conv in=0x%04h out=0x%02h%02h exp=0x%04h edges=%0d exp_edges=%0d",
                 f, out_hi, out_lo, exp_res, edges, exp_lat);
        check("latency", edges, exp_lat);
        check("result", {16'd0, out_hi, out_lo}, {16'd0, exp_res});
        check("wr_lo_once", wr_lo_cnt - lo0, 1);
        check("wr_hi_once", wr_hi_cnt - hi0, 1);
        check("no_stray_wr", bad_wr_cnt - bad0, 0);
    endtask

    logic [15:0] directed [9] = '{16'h4A40, 16'hC500, 16'h7400, 16'h7800, 16'hF800,
                                  16'h7C00, 16'h3BFF, 16'h8000, 16'h0001};

    initial begin
        int lo0, hi0;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; in_lo = 8'h00; in_hi = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wr_data}, 32'd0);

        // Reset wins over start at the same edge.
        @(negedge clk); start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); start = 1'b0; reset = 1'b0;
        lo0 = wr_lo_cnt; hi0 = wr_hi_cnt;
        repeat (15) @(posedge clk);
        #1;
        $display("reset_vs_start done=%0d writes=%0d", done, wr_lo_cnt + wr_hi_cnt - lo0 - hi0);
        check("rst_over_start_done", {31'd0, done}, 32'd0);
        check("rst_over_start_wr", wr_lo_cnt + wr_hi_cnt - lo0 - hi0, 0);

        foreach (directed[i]) convert(directed[i], 1'b0);
        for (int i = 0; i < 40; i++) convert(16'($urandom_range(0, 65535)), 1'b0);

        // Reset while shifting 0x4A40 (7 right shifts): conversion must abort silently.
        @(negedge clk);
        in_lo = 8'h40; in_hi = 8'h4A;
        lo0 = wr_lo_cnt; hi0 = wr_hi_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("abort_addr", {24'd0, mem_addr}, 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("abort done=%0d writes=%0d", done, wr_lo_cnt + wr_hi_cnt - lo0 - hi0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_no_write", wr_lo_cnt + wr_hi_cnt - lo0 - hi0, 0);
        convert(16'h4A40, 1'b0);

        // Start held high: each conversion restarts straight out of DONE.
        for (int i = 0; i < 4; i++) convert(16'($urandom_range(0, 65535)), 1'b1);
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);

        check("no_stray_total", bad_wr_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
